inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences instruction fetch from the synchronous instruction ROM (1-cycle read latency, word-addressed by PC[ADDR_W+1:2]).
- Owns the PC and issues ROM reads.
- Captures each returned word into a one-entry output register and hands it to the decode/display stage over a valid/ready handshake.
- Supports free-run, single-step and PC redirect (jump/branch), replacing the bare PC+4 loop around the ROM.

Parameters:
- ADDR_W, 6: ROM word-address width; PC is ADDR_W+2 bits (byte address).
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value after reset (byte address; low two bits must be 0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level: continuous fetch enable.
- step  in  1  pulse: fetch exactly one instruction while run=0.
- redirect_valid  in  1  load new PC; flush any fetch in progress.
- redirect_pc  in  ADDR_W+2  new byte PC; bits [1:0] ignored (forced 0).
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2].
- rom_data  in  DATA_W  ROM read data, valid the cycle after rom_en.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  consumer accepts instruction when inst_valid && inst_ready.
- inst  out  DATA_W  fetched instruction.
- inst_pc  out  ADDR_W+2  byte PC of inst.
- pc  out  ADDR_W+2  next PC to be fetched.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at clk edge) sets:
  - pc=RESET_PC, state=IDLE, step_pending=0
  - inst_valid=0, inst=0, inst_pc=0
  - rom_en=0, rom_addr reflects pc.
- rst overrides every other input, including during an in-flight fetch. The returned ROM word is discarded.
- States: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE: rom_en=0.
  - Next state is ISSUE if run=1 or step_pending=1.
  - Otherwise remain in IDLE.
- ISSUE: rom_en=1 with rom_addr=pc[ADDR_W+1:2].
  - issued_pc<=pc; pc<=pc+4 (modulo 2^(ADDR_W+2), so 0xFC wraps to 0x00 at ADDR_W=6).
  - step_pending<=0.
  - Next state is CAPTURE.
- CAPTURE: rom_en=0.
  - inst<=rom_data; inst_pc<=issued_pc; inst_valid<=1.
  - Next state is HOLD.
- HOLD: inst_valid=1; inst and inst_pc stay stable until accepted.
  - On inst_ready=1: inst_valid<=0. Next state is ISSUE if run=1 or step_pending=1, else IDLE.
- Latency:
  - Run start to inst_valid is 3 cycles: IDLE→ISSUE→CAPTURE→HOLD.
  - Steady-state throughput with inst_ready held high is 1 instruction per 3 cycles.
- step:
  - A step pulse with run=0 sets step_pending (in any state).
  - Multiple pulses before consumption collapse to one.
  - step while run=1 is ignored.
- run deasserted mid-fetch: the in-flight instruction still completes and is delivered. The FSM then returns to IDLE after acceptance.
- redirect_valid=1 (priority below rst only), in any state:
  - pc<=redirect_pc with [1:0]=0.
  - inst_valid<=0; any in-flight or held instruction is discarded.
  - step_pending is unchanged; state<=IDLE.
  - The first fetch from the new PC issues the following cycle if run or step_pending.
- redirect coinciding with an inst_ready handshake: the handshake is void and the instruction is dropped.
- Outputs inst, inst_pc, inst_valid and busy are registered. rom_en and rom_addr are decoded from state and pc.

Decomposition:
- Package fetch_pkg holds:
  - state enum FETCH_IDLE/ISSUE/CAPTURE/HOLD
  - PC_INC=4
  - default ADDR_W/DATA_W
- Single module, no sub-module. The ROM stays external and is instantiated alongside by the parent.

Test Plan:
- ROM model: mem[i]=32'hA500_0000|i.
- Reset then run=1 with inst_ready=1 → inst_valid on cycles 3, 6 and 9 with inst=A5000000/A5000001/A5000002 and inst_pc=0x00/0x04/0x08.
- run=0, one step pulse → exactly one instruction (A5000000, inst_pc=0x00), then busy=0 and pc=0x04. A second step → A5000001.
- run=1, inst_ready=0 for 5 cycles in HOLD → inst stays A5000000, rom_en stays 0, pc stays 0x04. Raising ready → next issue at 0x04.
- redirect_valid with redirect_pc=0x23 during CAPTURE → no delivery of the in-flight word; next inst_pc=0x20, inst=A5000008.
- Start at pc=0xFC via redirect, run → inst_pc 0xFC (A500003F) then 0x00 (A5000000); wrap verified.
- rst asserted during ISSUE → next cycle pc=RESET_PC, inst_valid=0, state IDLE. The returned ROM word is never presented.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_ISSUE,
      FETCH_CAPTURE,
      FETCH_HOLD
   } fetch_state_e;

   localparam int PC_INC     = 4;
   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a 1-cycle-latency ROM and
// presents each word through a one-entry valid/ready output register.
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic              redirect_valid,
   input  logic [ADDR_W+1:0] redirect_pc,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W+1:0] inst_pc,
   output logic [ADDR_W+1:0] pc,
   output logic              busy
);

   localparam int PC_W = ADDR_W + 2;

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   issued_pc_q, issued_pc_d;
   logic              step_pend_q, step_pend_d;
   logic              inst_valid_q, inst_valid_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
   logic              busy_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      issued_pc_d  = issued_pc_q;
      step_pend_d  = step_pend_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;

      case (state_q)
         FETCH_IDLE: begin
            if (run || step_pend_q) state_d = FETCH_ISSUE;
         end
         FETCH_ISSUE: begin
            issued_pc_d = pc_q;
            pc_d        = pc_q + PC_W'(PC_INC);
            step_pend_d = 1'b0;
            state_d     = FETCH_CAPTURE;
         end
         FETCH_CAPTURE: begin
            inst_d       = rom_data;
            inst_pc_d    = issued_pc_q;
            inst_valid_d = 1'b1;
            state_d      = FETCH_HOLD;
         end
         FETCH_HOLD: begin
            if (inst_ready) begin
               inst_valid_d = 1'b0;
               state_d      = (run || step_pend_q) ? FETCH_ISSUE : FETCH_IDLE;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase

      // A redirect voids whatever is in flight or held, including a same-cycle handshake.
      if (redirect_valid) begin
         pc_d         = {redirect_pc[PC_W-1:2], 2'b00};
         inst_valid_d = 1'b0;
         step_pend_d  = step_pend_q;
         state_d      = FETCH_IDLE;
      end

      if (step && !run) step_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH_IDLE;
         pc_q         <= RESET_PC;
         step_pend_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         step_pend_q  <= step_pend_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         busy_q       <= (state_d != FETCH_IDLE);
      end
      issued_pc_q <= issued_pc_d;
   end

   assign rom_en     = (state_q == FETCH_ISSUE);
   assign rom_addr   = pc_q[PC_W-1:2];
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign pc         = pc_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: external ROM model, per-cycle comparison against
// a behavioural reference, and directed scenarios with literal expectations.
module tb_inst_fetch_ctrl;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int PW = AW + 2;

   logic          clk;
   logic          rst, run, step, redirect_valid, inst_ready;
   logic [PW-1:0] redirect_pc;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          inst_valid;
   logic [DW-1:0] inst;
   logic [PW-1:0] inst_pc, pc;
   logic          busy;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 0;
   logic [39:0] dq[$];

   inst_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .pc(pc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [7:0] bpc);
      return 32'hA500_0000 | {26'd0, bpc[7:2]};
   endfunction

   always @(posedge clk) if (rom_en) rom_data <= rom_word({rom_addr, 2'b00});

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference: phase 0 idle, 1 address out, 2 data returning, 3 waiting on consumer.
   int         m_phase;
   logic [7:0] m_pc, m_ipc, m_inst_pc;
   logic [31:0] m_inst;
   logic       m_vld, m_step;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0; m_pc <= 8'h00; m_step <= 1'b0;
         m_vld <= 1'b0; m_inst <= 32'd0; m_inst_pc <= 8'h00;
      end else begin
         if (redirect_valid) begin
            m_pc <= {redirect_pc[7:2], 2'b00};
            m_vld <= 1'b0;
            m_phase <= 0;
         end else begin
            case (m_phase)
               0: if (run || m_step) m_phase <= 1;
               1: begin m_ipc <= m_pc; m_pc <= m_pc + 8'd4; m_phase <= 2; end
               2: begin m_vld <= 1'b1; m_inst <= rom_word(m_ipc); m_inst_pc <= m_ipc; m_phase <= 3; end
               default: if (inst_ready) begin m_vld <= 1'b0; m_phase <= (run || m_step) ? 1 : 0; end
            endcase
         end
         if (step && !run) m_step <= 1'b1;
         else if (m_phase == 1 && !redirect_valid) m_step <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_pc", 64'(pc), 64'(m_pc));
         chk("cyc_rom_en", 64'(rom_en), 64'(m_phase == 1));
         chk("cyc_rom_addr", 64'(rom_addr), 64'(m_pc[7:2]));
         chk("cyc_inst_valid", 64'(inst_valid), 64'(m_vld));
         chk("cyc_busy", 64'(busy), 64'(m_phase != 0));
         if (m_vld) begin
            chk("cyc_inst", 64'(inst), 64'(m_inst));
            chk("cyc_inst_pc", 64'(inst_pc), 64'(m_inst_pc));
         end
      end
      if (inst_valid && inst_ready && !redirect_valid && !rst) dq.push_back({inst_pc, inst});
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; step = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string nm, input int max);
      int k = 0;
      while (!inst_valid && k < max) begin tick(1); k++; end
      chk(nm, 64'(inst_valid), 64'd1);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; step = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; inst_ready = 1'b0;
      tick(2);
      chk_en = 1;
      rst = 1'b0;

      // Reset state
      chk("rst_pc", 64'(pc), 64'h00);
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rom_en", 64'(rom_en), 64'd0);

      // Free run, ready high: valid three cycles after start, then every three
      run = 1'b1; inst_ready = 1'b1;
      tick(2);
      chk("run_not_yet", 64'(inst_valid), 64'd0);
      tick(1);
      chk("run_v1", 64'(inst_valid), 64'd1);
      chk("run_i1", 64'(inst), 64'hA500_0000);
      chk("run_p1", 64'(inst_pc), 64'h00);
      tick(3);
      chk("run_v2", 64'(inst_valid), 64'd1);
      chk("run_i2", 64'(inst), 64'hA500_0001);
      chk("run_p2", 64'(inst_pc), 64'h04);
      tick(3);
      chk("run_v3", 64'(inst_valid), 64'd1);
      chk("run_i3", 64'(inst), 64'hA500_0002);
      chk("run_p3", 64'(inst_pc), 64'h08);
      run = 1'b0;
      tick(2);
      chk("run_stop_pc", 64'(pc), 64'h0C);
      chk("run_stop_busy", 64'(busy), 64'd0);

      // Single step
      do_reset();
      inst_ready = 1'b1;
      dq.delete();
      step = 1'b1; tick(1); step = 1'b0;
      tick(8);
      chk("step1_count", 64'(dq.size()), 64'd1);
      if (dq.size() >= 1) chk("step1_word", 64'(dq[0]), 64'({8'h00, 32'hA500_0000}));
      chk("step1_busy", 64'(busy), 64'd0);
      chk("step1_pc", 64'(pc), 64'h04);
      dq.delete();
      step = 1'b1; tick(1); step = 1'b0;
      tick(8);
      chk("step2_count", 64'(dq.size()), 64'd1);
      if (dq.size() >= 1) chk("step2_word", 64'(dq[0]), 64'({8'h04, 32'hA500_0001}));

      // Back-pressure in HOLD
      do_reset();
      run = 1'b1; inst_ready = 1'b0;
      tick(3);
      for (int i = 0; i < 5; i++) begin
         chk("hold_inst", 64'(inst), 64'hA500_0000);
         chk("hold_rom_en", 64'(rom_en), 64'd0);
         chk("hold_pc", 64'(pc), 64'h04);
         tick(1);
      end
      inst_ready = 1'b1;
      tick(1);
      chk("hold_reissue_en", 64'(rom_en), 64'd1);
      chk("hold_reissue_addr", 64'(rom_addr), 64'd1);
      run = 1'b0;
      tick(4);

      // Redirect during CAPTURE drops the in-flight word
      do_reset();
      run = 1'b1; inst_ready = 1'b1;
      dq.delete();
      tick(2);
      redirect_valid = 1'b1; redirect_pc = 8'h23;
      tick(1);
      redirect_valid = 1'b0;
      chk("redir_valid", 64'(inst_valid), 64'd0);
      chk("redir_pc", 64'(pc), 64'h20);
      wait_valid("redir_timeout", 10);
      chk("redir_inst_pc", 64'(inst_pc), 64'h20);
      chk("redir_inst", 64'(inst), 64'hA500_0008);
      chk("redir_no_old", 64'(dq.size()), 64'd0);
      run = 1'b0;
      tick(3);

      // PC wrap from 0xFC
      do_reset();
      inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 8'hFC;
      tick(1);
      redirect_valid = 1'b0;
      dq.delete();
      run = 1'b1;
      for (int k = 0; k < 12 && dq.size() < 2; k++) tick(1);
      run = 1'b0;
      chk("wrap_count", 64'(dq.size() >= 2), 64'd1);
      if (dq.size() >= 2) begin
         chk("wrap_first", 64'(dq[0]), 64'({8'hFC, 32'hA500_003F}));
         chk("wrap_second", 64'(dq[1]), 64'({8'h00, 32'hA500_0000}));
      end
      tick(4);

      // Reset during ISSUE
      do_reset();
      run = 1'b1; inst_ready = 1'b1;
      tick(1);
      chk("rsti_rom_en", 64'(rom_en), 64'd1);
      dq.delete();
      rst = 1'b1;
      tick(1);
      rst = 1'b0; run = 1'b0;
      chk("rsti_pc", 64'(pc), 64'h00);
      chk("rsti_valid", 64'(inst_valid), 64'd0);
      chk("rsti_busy", 64'(busy), 64'd0);
      tick(4);
      chk("rsti_no_word", 64'(dq.size()), 64'd0);
      chk("rsti_still_idle", 64'(inst_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
